// File: rtl/alu_pkg.sv
// ALU encodings shared by the issue stage, the control decoder and the EX-stage ALU.
// Pure constants and types; no logic, no latency, no backpressure.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ORI   = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> 4-bit ALU control decoder with illegal-funct flag.
// Zero latency; no handshake, so no backpressure of its own.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl.alu_control = ALU_AND;
    o_ctrl.illegal     = 1'b0;
    case (aluop_e'(i_alu_op))
      ALUOP_ADD: o_ctrl.alu_control = ALU_ADD;
      ALUOP_SUB: o_ctrl.alu_control = ALU_SUB;
      ALUOP_ORI: o_ctrl.alu_control = ALU_OR;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_ctrl.alu_control = ALU_ADD;
          FUNCT_SUB: o_ctrl.alu_control = ALU_SUB;
          FUNCT_AND: o_ctrl.alu_control = ALU_AND;
          FUNCT_OR:  o_ctrl.alu_control = ALU_OR;
          FUNCT_NOR: o_ctrl.alu_control = ALU_NOR;
          FUNCT_SLT: o_ctrl.alu_control = ALU_SLT;
          default:   o_ctrl.illegal     = 1'b1;
        endcase
      end
      default: o_ctrl.alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decodes ID ops into ALU control + operands and queues them (2 entries) toward EX; push->out_valid 1 cycle.
// in_ready depends only on registered occupancy, so EX stalls back-pressure ID with no comb path from out_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [5:0]        in_funct,
  input  logic              in_alu_src,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_control,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  typedef struct packed {
    logic [3:0]        alu_control;
    logic              illegal;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } entry_t;

  entry_t            r_mem [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_count;
  logic [CNT_W-1:0]  r_illegal_count;

  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_data2;
  entry_t            w_entry;
  entry_t            w_head;
  logic              w_push;
  logic              w_pop;

  alu_ctrl_decode u_decode (
    .i_alu_op (in_alu_op),
    .i_funct  (in_funct),
    .o_ctrl   (w_ctrl)
  );

  // ori takes a zero-extended immediate; every other immediate form is sign-extended
  always_comb begin
    w_data2 = in_rt_data;
    if (in_alu_src) begin
      if (aluop_e'(in_alu_op) == ALUOP_ORI)
        w_data2 = {{(DATA_W-16){1'b0}}, in_imm};
      else
        w_data2 = {{(DATA_W-16){in_imm[15]}}, in_imm};
    end
  end

  assign w_entry.alu_control = w_ctrl.alu_control;
  assign w_entry.illegal     = w_ctrl.illegal;
  assign w_entry.data1       = in_rs_data;
  assign w_entry.data2       = w_data2;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_entry;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Counts accepted illegal ops even in a flush cycle, since ID did hand them over
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal_count <= '0;
    else if (w_push && w_ctrl.illegal && (r_illegal_count != '1))
      r_illegal_count <= r_illegal_count + CNT_W'(1);
  end

  assign w_head          = r_mem[r_head];
  assign out_alu_control = w_head.alu_control;
  assign out_data1       = w_head.data1;
  assign out_data2       = w_head.data2;
  assign out_illegal     = w_head.illegal;
  assign illegal_count   = r_illegal_count;

endmodule
